// File: rtl/vga_letter_pkg.sv
// vga_letter_pkg: shared constants, sprite command record and command-slot states.
package vga_letter_pkg;
  localparam int GLYPH_LOG2 = 3;
  localparam int SCALE_LOG2 = 2;
  localparam int CODE_W = 6;
  localparam int ROM_AW = CODE_W + GLYPH_LOG2;
  localparam int SPRITE_SIZE = 1 << (GLYPH_LOG2 + SCALE_LOG2);
  localparam logic [2:0] COLOR_BG = 3'b000;
  localparam logic [2:0] COLOR_FG = 3'b111;
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [9:0] posx;
    logic [9:0] posy;
  } letter_cmd_t;
  typedef enum logic {EMPTY, PENDING} cmd_state_t;
endpackage

// File: rtl/letter_font_rom.sv
// letter_font_rom: 512x8 glyph ROM, address {code,row}, one-cycle registered read, MSB = leftmost cell.
module letter_font_rom
  import vga_letter_pkg::*;
(
  input  logic clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [7:0] data
);
  always_ff @(posedge clk)
    case (addr)
      {6'd1, 3'd0}: data <= 8'h18;
      {6'd1, 3'd1}: data <= 8'h3C;
      {6'd1, 3'd2}: data <= 8'h66;
      {6'd1, 3'd3}: data <= 8'h66;
      {6'd1, 3'd4}: data <= 8'h7E;
      {6'd1, 3'd5}: data <= 8'h66;
      {6'd1, 3'd6}: data <= 8'h66;
      {6'd2, 3'd0}: data <= 8'h7C;
      {6'd2, 3'd1}: data <= 8'h66;
      {6'd2, 3'd2}: data <= 8'h66;
      {6'd2, 3'd3}: data <= 8'h7C;
      {6'd2, 3'd4}: data <= 8'h66;
      {6'd2, 3'd5}: data <= 8'h66;
      {6'd2, 3'd6}: data <= 8'h7C;
      {6'd3, 3'd0}: data <= 8'h3C;
      {6'd3, 3'd1}: data <= 8'h66;
      {6'd3, 3'd2}: data <= 8'h60;
      {6'd3, 3'd3}: data <= 8'h60;
      {6'd3, 3'd4}: data <= 8'h60;
      {6'd3, 3'd5}: data <= 8'h66;
      {6'd3, 3'd6}: data <= 8'h3C;
      {6'd4, 3'd0}: data <= 8'h78;
      {6'd4, 3'd1}: data <= 8'h6C;
      {6'd4, 3'd2}: data <= 8'h66;
      {6'd4, 3'd3}: data <= 8'h66;
      {6'd4, 3'd4}: data <= 8'h66;
      {6'd4, 3'd5}: data <= 8'h6C;
      {6'd4, 3'd6}: data <= 8'h78;
      {6'd5, 3'd0}: data <= 8'h7E;
      {6'd5, 3'd1}: data <= 8'h60;
      {6'd5, 3'd2}: data <= 8'h60;
      {6'd5, 3'd3}: data <= 8'h78;
      {6'd5, 3'd4}: data <= 8'h60;
      {6'd5, 3'd5}: data <= 8'h60;
      {6'd5, 3'd6}: data <= 8'h7E;
      {6'd6, 3'd0}: data <= 8'h7E;
      {6'd6, 3'd1}: data <= 8'h60;
      {6'd6, 3'd2}: data <= 8'h60;
      {6'd6, 3'd3}: data <= 8'h78;
      {6'd6, 3'd4}: data <= 8'h60;
      {6'd6, 3'd5}: data <= 8'h60;
      {6'd6, 3'd6}: data <= 8'h60;
      {6'd7, 3'd0}: data <= 8'h3C;
      {6'd7, 3'd1}: data <= 8'h66;
      {6'd7, 3'd2}: data <= 8'h60;
      {6'd7, 3'd3}: data <= 8'h6E;
      {6'd7, 3'd4}: data <= 8'h66;
      {6'd7, 3'd5}: data <= 8'h66;
      {6'd7, 3'd6}: data <= 8'h3C;
      {6'd8, 3'd0}: data <= 8'h66;
      {6'd8, 3'd1}: data <= 8'h66;
      {6'd8, 3'd2}: data <= 8'h66;
      {6'd8, 3'd3}: data <= 8'h7E;
      {6'd8, 3'd4}: data <= 8'h66;
      {6'd8, 3'd5}: data <= 8'h66;
      {6'd8, 3'd6}: data <= 8'h66;
      {6'd9, 3'd0}: data <= 8'h3C;
      {6'd9, 3'd1}: data <= 8'h18;
      {6'd9, 3'd2}: data <= 8'h18;
      {6'd9, 3'd3}: data <= 8'h18;
      {6'd9, 3'd4}: data <= 8'h18;
      {6'd9, 3'd5}: data <= 8'h18;
      {6'd9, 3'd6}: data <= 8'h3C;
      {6'd10, 3'd0}: data <= 8'h1E;
      {6'd10, 3'd1}: data <= 8'h0C;
      {6'd10, 3'd2}: data <= 8'h0C;
      {6'd10, 3'd3}: data <= 8'h0C;
      {6'd10, 3'd4}: data <= 8'h6C;
      {6'd10, 3'd5}: data <= 8'h6C;
      {6'd10, 3'd6}: data <= 8'h38;
      {6'd11, 3'd0}: data <= 8'h66;
      {6'd11, 3'd1}: data <= 8'h6C;
      {6'd11, 3'd2}: data <= 8'h78;
      {6'd11, 3'd3}: data <= 8'h70;
      {6'd11, 3'd4}: data <= 8'h78;
      {6'd11, 3'd5}: data <= 8'h6C;
      {6'd11, 3'd6}: data <= 8'h66;
      {6'd12, 3'd0}: data <= 8'h60;
      {6'd12, 3'd1}: data <= 8'h60;
      {6'd12, 3'd2}: data <= 8'h60;
      {6'd12, 3'd3}: data <= 8'h60;
      {6'd12, 3'd4}: data <= 8'h60;
      {6'd12, 3'd5}: data <= 8'h60;
      {6'd12, 3'd6}: data <= 8'h7E;
      {6'd13, 3'd0}: data <= 8'h63;
      {6'd13, 3'd1}: data <= 8'h77;
      {6'd13, 3'd2}: data <= 8'h7F;
      {6'd13, 3'd3}: data <= 8'h6B;
      {6'd13, 3'd4}: data <= 8'h63;
      {6'd13, 3'd5}: data <= 8'h63;
      {6'd13, 3'd6}: data <= 8'h63;
      {6'd14, 3'd0}: data <= 8'h66;
      {6'd14, 3'd1}: data <= 8'h76;
      {6'd14, 3'd2}: data <= 8'h7E;
      {6'd14, 3'd3}: data <= 8'h7E;
      {6'd14, 3'd4}: data <= 8'h6E;
      {6'd14, 3'd5}: data <= 8'h66;
      {6'd14, 3'd6}: data <= 8'h66;
      {6'd15, 3'd0}: data <= 8'h3C;
      {6'd15, 3'd1}: data <= 8'h66;
      {6'd15, 3'd2}: data <= 8'h66;
      {6'd15, 3'd3}: data <= 8'h66;
      {6'd15, 3'd4}: data <= 8'h66;
      {6'd15, 3'd5}: data <= 8'h66;
      {6'd15, 3'd6}: data <= 8'h3C;
      {6'd16, 3'd0}: data <= 8'h7C;
      {6'd16, 3'd1}: data <= 8'h66;
      {6'd16, 3'd2}: data <= 8'h66;
      {6'd16, 3'd3}: data <= 8'h7C;
      {6'd16, 3'd4}: data <= 8'h60;
      {6'd16, 3'd5}: data <= 8'h60;
      {6'd16, 3'd6}: data <= 8'h60;
      default: data <= 8'h00;
    endcase
endmodule

// File: rtl/vga_letter_sprite_fetch.sv
// vga_letter_sprite_fetch: one-letter sprite with frame-synchronous updates and a 2-cycle font fetch pipeline.
// Define VGA_LETTER_BLINK_EN to blank the glyph on alternate 32-frame periods.
module vga_letter_sprite_fetch
  import vga_letter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [CODE_W-1:0] cmd_code,
  input  logic [9:0] cmd_posx,
  input  logic [9:0] cmd_posy,
  input  logic frame_start,
  input  logic [9:0] counterX,
  input  logic [9:0] counterY,
  input  logic video_on,
  output logic [2:0] color,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic [9:0] counterX_o,
  output logic [9:0] counterY_o,
  output logic sprite_hit
);
  cmd_state_t state;
  letter_cmd_t shadow, active;
  logic [10:0] dx, dy;
  logic hit, hit_q, blank;
  logic [GLYPH_LOG2-1:0] col_q;
  logic [7:0] row;
  logic [9:0] posx_q, posy_q, cx_q, cy_q;
  assign cmd_ready = (state == EMPTY) && rst_n;
  // Shadow slot: only frame_start moves it into the displayed registers.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= EMPTY;
      shadow <= '0;
      active <= '0;
    end else if (state == EMPTY) begin
      if (cmd_valid) begin
        shadow <= '{code: cmd_code, posx: cmd_posx, posy: cmd_posy};
        state <= PENDING;
      end
    end else if (frame_start) begin
      active <= shadow;
      state <= EMPTY;
    end
  assign dx = {1'b0, counterX} - {1'b0, active.posx};
  assign dy = {1'b0, counterY} - {1'b0, active.posy};
  assign hit = video_on && counterX >= active.posx && counterY >= active.posy &&
               dx < 11'(SPRITE_SIZE) && dy < 11'(SPRITE_SIZE);
  letter_font_rom u_rom (
    .clk(clk),
    .addr({active.code, dy[SCALE_LOG2 +: GLYPH_LOG2]}),
    .data(row)
  );
`ifdef VGA_LETTER_BLINK_EN
  logic [5:0] frame_cnt;
  always_ff @(posedge clk)
    if (!rst_n) frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 6'd1;
  assign blank = frame_cnt[5];
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      hit_q <= 1'b0;
      col_q <= '0;
      posx_q <= '0;
      posy_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      color <= COLOR_BG;
      sprite_hit <= 1'b0;
      posx <= '0;
      posy <= '0;
      counterX_o <= '0;
      counterY_o <= '0;
    end else begin
      hit_q <= hit;
      col_q <= dx[SCALE_LOG2 +: GLYPH_LOG2];
      posx_q <= active.posx;
      posy_q <= active.posy;
      cx_q <= counterX;
      cy_q <= counterY;
      color <= (hit_q && row[3'd7 - col_q] && !blank) ? COLOR_FG : COLOR_BG;
      sprite_hit <= hit_q;
      posx <= posx_q;
      posy <= posy_q;
      counterX_o <= cx_q;
      counterY_o <= cy_q;
    end
endmodule

// File: tb/tb_vga_letter_sprite_fetch.sv
// tb_vga_letter_sprite_fetch: directed vectors for the letter sprite fetch stage.
module tb_vga_letter_sprite_fetch;
  logic clk, rst_n, cmd_valid, cmd_ready, frame_start, video_on, sprite_hit;
  logic [5:0] cmd_code;
  logic [9:0] cmd_posx, cmd_posy, counterX, counterY, posx, posy, counterX_o, counterY_o;
  logic [2:0] color;
  int n_vec = 0;
  int n_err = 0;
  int frames = 0;
  logic [7:0] a_row0 = 8'h18;
  vga_letter_sprite_fetch dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_posx(cmd_posx), .cmd_posy(cmd_posy),
    .frame_start(frame_start), .counterX(counterX), .counterY(counterY),
    .video_on(video_on), .color(color), .posx(posx), .posy(posy),
    .counterX_o(counterX_o), .counterY_o(counterY_o), .sprite_hit(sprite_hit)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input int x, input int y);
    counterX = 10'(x);
    counterY = 10'(y);
    step();
    step();
  endtask
  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    frames++;
  endtask
  task automatic send(input int code, input int x, input int y);
    cmd_valid = 1'b1;
    cmd_code = 6'(code);
    cmd_posx = 10'(x);
    cmd_posy = 10'(y);
    step();
    cmd_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = '0; cmd_posx = '0; cmd_posy = '0;
    frame_start = 1'b0; counterX = '0; counterY = '0; video_on = 1'b1;
    repeat (3) step();
    check("rst_color", color, 3'b000);
    check("rst_hit", sprite_hit, 1'b0);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_posx", posx, 10'd0);
    check("rst_cxo", counterX_o, 10'd0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", cmd_ready, 1'b1);
    send(1, 100, 50);
    check("ready_pending", cmd_ready, 1'b0);
    frame_pulse();
    check("ready_applied", cmd_ready, 1'b1);
    counterY = 10'd50;
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) counterX = 10'(100 + i);
      step();
      if (i >= 1) begin
        check($sformatf("sweep_col_%0d", 99 + i), color, a_row0[7 - (i - 1) / 4] ? 3'b111 : 3'b000);
        check($sformatf("sweep_hit_%0d", 99 + i), sprite_hit, 1'b1);
        check($sformatf("sweep_cxo_%0d", 99 + i), counterX_o, 10'(99 + i));
      end
    end
    check("sweep_posx", posx, 10'd100);
    check("sweep_posy", posy, 10'd50);
    pix(99, 50);   check("left_col", color, 3'b000);  check("left_hit", sprite_hit, 1'b0);
    pix(132, 50);  check("right_col", color, 3'b000); check("right_hit", sprite_hit, 1'b0);
    pix(100, 82);  check("below_col", color, 3'b000); check("below_hit", sprite_hit, 1'b0);
    pix(100, 66);  check("r4c0_col", color, 3'b000);  check("r4c0_hit", sprite_hit, 1'b1);
    pix(104, 66);  check("r4c1_col", color, 3'b111);  check("r4c1_cyo", counterY_o, 10'd66);
    video_on = 1'b0;
    pix(112, 50);  check("voff_col", color, 3'b000);  check("voff_hit", sprite_hit, 1'b0);
    video_on = 1'b1;
    cmd_valid = 1'b1; cmd_code = 6'd2; cmd_posx = 10'd200; cmd_posy = 10'd100;
    step();
    cmd_code = 6'd3; cmd_posx = 10'd300; cmd_posy = 10'd200;
    check("b2b_ready0", cmd_ready, 1'b0);
    pix(112, 50);  check("b2b_old_col", color, 3'b111); check("b2b_ready1", cmd_ready, 1'b0);
    frame_pulse();
    check("b2b_ready_fs", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("b2b_ready2", cmd_ready, 1'b0);
    pix(204, 100); check("b2b_first_col", color, 3'b111); check("b2b_first_posx", posx, 10'd200);
    pix(200, 100); check("b2b_first_c0", color, 3'b000);  check("b2b_first_hit", sprite_hit, 1'b1);
    pix(312, 200); check("b2b_second_hit", sprite_hit, 1'b0);
    frame_pulse();
    pix(304, 200); check("c_c1_col", color, 3'b000); check("c_c1_hit", sprite_hit, 1'b1);
    pix(308, 200); check("c_c2_col", color, 3'b111); check("c_posy", posy, 10'd200);
    send(1, 1000, 0);
    frame_pulse();
    pix(5, 0);     check("nowrap_hit", sprite_hit, 1'b0); check("nowrap_col", color, 3'b000);
    pix(1000, 0);  check("edge_hit", sprite_hit, 1'b1);   check("edge_col", color, 3'b000);
    pix(1012, 0);  check("edge_c3_col", color, 3'b111);
    cmd_valid = 1'b1; cmd_code = 6'd2; cmd_posx = 10'd10; cmd_posy = 10'd10;
    frame_pulse();
    cmd_valid = 1'b0;
    check("same_ready", cmd_ready, 1'b0);
    pix(14, 10);   check("same_not_applied", sprite_hit, 1'b0);
    pix(1012, 0);  check("same_old_col", color, 3'b111);
    frame_pulse();
    pix(14, 10);   check("same_applied_col", color, 3'b111); check("same_applied_hit", sprite_hit, 1'b1);
    while (frames < 31) frame_pulse();
    pix(14, 10);   check("f31_col", color, 3'b111);
    frame_pulse();
`ifdef VGA_LETTER_BLINK_EN
    pix(14, 10);   check("f32_col", color, 3'b000);
`else
    pix(14, 10);   check("f32_col", color, 3'b111);
`endif
    check("f32_hit", sprite_hit, 1'b1);
    while (frames < 40) frame_pulse();
`ifdef VGA_LETTER_BLINK_EN
    pix(14, 10);   check("f40_col", color, 3'b000);
`else
    pix(14, 10);   check("f40_col", color, 3'b111);
`endif
    check("f40_hit", sprite_hit, 1'b1);
    while (frames < 64) frame_pulse();
    pix(14, 10);   check("f64_col", color, 3'b111);
    send(1, 500, 400);
    rst_n = 1'b0;
    step();
    check("mid_rst_ready", cmd_ready, 1'b0);
    check("mid_rst_col", color, 3'b000);
    check("mid_rst_posx", posx, 10'd0);
    rst_n = 1'b1;
    step();
    check("mid_rst_ready1", cmd_ready, 1'b1);
    frame_pulse();
    pix(512, 400); check("discard_hit", sprite_hit, 1'b0);
    pix(5, 5);     check("home_hit", sprite_hit, 1'b1); check("home_col", color, 3'b000);
    check("home_cxo", counterX_o, 10'd5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
